// File: rtl/barrel_dispatcher.sv
// -----------------------------------------------------------------------------
// barrel_dispatcher
//
// Turns the kong "drop" animation into barrel spawn requests. Each rising edge
// of drop_req (sampled on a game tick) looks for a free barrel slot, searching
// round-robin from the slot after the last one used. It raises that slot's
// start line until the slot reports busy, or gives up after 8 ticks. It keeps
// a mask of slots it owns, and counts successful spawns and discarded drops.
//
// Optional feature (macro BARREL_COOLDOWN_EN): after each request the block
// enters a cooldown of COOLDOWN_TICKS ticks. Drops that arrive during the
// cooldown are counted as misses. Without the macro, REQ returns straight to
// IDLE and COOLDOWN_TICKS has no effect.
//
// Ports
//   clk          system clock
//   rst_n        asynchronous active-low reset
//   tick         one-clk game-rate enable; all state advances only on it
//   game_run     high while the game is RUNNING
//   game_clear   synchronous clear (game INITIAL), priority over tick
//   drop_req     level, high while kong is in DROP pose
//   slot_busy    per-slot flag, high while that barrel is rolling/falling
//   slot_start   one-hot-or-zero start request to barrel slots
//   active_mask  slots allocated here and not yet released
//   spawn_count  saturating count of acknowledged spawns
//   miss_count   saturating count of discarded drop events
//   all_busy     active_mask is all ones
// -----------------------------------------------------------------------------
module barrel_dispatcher #(
  parameter int NUM_SLOTS      = 16,
  parameter int COOLDOWN_TICKS = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 tick,
  input  logic                 game_run,
  input  logic                 game_clear,
  input  logic                 drop_req,
  input  logic [NUM_SLOTS-1:0] slot_busy,
  output logic [NUM_SLOTS-1:0] slot_start,
  output logic [NUM_SLOTS-1:0] active_mask,
  output logic [7:0]           spawn_count,
  output logic [7:0]           miss_count,
  output logic                 all_busy
);

  localparam int IW = $clog2(NUM_SLOTS);
  localparam logic [NUM_SLOTS-1:0] ONE_HOT0 = NUM_SLOTS'(1);

  typedef enum logic [1:0] {IDLE, SEARCH, REQ, COOL} state_t;

  state_t               r_state;
  logic                 r_drop_q;
  logic [NUM_SLOTS-1:0] r_busy_q;
  logic [IW-1:0]        r_ptr;
  logic [2:0]           r_to;
  logic [NUM_SLOTS-1:0] r_start;
  logic [NUM_SLOTS-1:0] r_active;
  logic [7:0]           r_spawn;
  logic [7:0]           r_miss;
  logic                 r_all_busy;

`ifdef BARREL_COOLDOWN_EN
  localparam logic [7:0] COOL_LOAD = 8'(COOLDOWN_TICKS);
  logic [7:0] r_cool;
  logic       w_cool_ok;
  assign w_cool_ok = (r_cool == 8'd0);
`else
  logic w_cool_ok;
  logic w_unused_cooldown;
  assign w_cool_ok         = 1'b1;
  assign w_unused_cooldown = (COOLDOWN_TICKS != 0);
`endif

  logic                 w_drop_evt;
  logic [NUM_SLOTS-1:0] w_release;
  logic [NUM_SLOTS-1:0] w_free;
  logic [NUM_SLOTS-1:0] w_rot;
  logic                 w_found;
  logic [IW-1:0]        w_off;
  logic [IW:0]          w_sum;
  logic [IW-1:0]        w_idx;
  logic [IW-1:0]        w_ptr_nxt;
  logic                 w_ack;
  logic                 w_timeout;
  logic [NUM_SLOTS-1:0] w_set;
  logic [NUM_SLOTS-1:0] w_drop_k;
  logic [NUM_SLOTS-1:0] w_active_nxt;

  assign w_drop_evt = drop_req & ~r_drop_q;
  // A slot is released when its busy flag falls between two ticks.
  assign w_release  = r_busy_q & ~slot_busy;
  // r_active still holds a slot released on this same tick, so a slot freed
  // concurrently with SEARCH only becomes eligible on the following tick.
  assign w_free     = ~r_active & ~slot_busy;

  // Rotate so that bit 0 is the round-robin pointer; the lowest set bit of
  // the rotated vector is then the first free slot at or after the pointer.
  assign w_rot   = NUM_SLOTS'({w_free, w_free} >> r_ptr);
  assign w_found = |w_rot;

  // NOTE: every always_comb output gets a default before any conditional
  // assignment, otherwise paths that skip it infer a latch.
  always_comb begin
    w_off = '0;
    for (int j = NUM_SLOTS - 1; j >= 0; j--) begin
      if (w_rot[j]) w_off = IW'(j);
    end
  end

  assign w_sum     = {1'b0, r_ptr} + {1'b0, w_off};
  assign w_idx     = (w_sum >= (IW+1)'(NUM_SLOTS)) ? IW'(w_sum - (IW+1)'(NUM_SLOTS))
                                                   : IW'(w_sum);
  assign w_ptr_nxt = (w_idx == IW'(NUM_SLOTS - 1)) ? '0 : w_idx + 1'b1;

  // r_start is one-hot on the requested slot while in REQ.
  assign w_ack     = |(r_start & slot_busy);
  assign w_timeout = (r_to == 3'd7) & ~w_ack;

  assign w_set        = (r_state == SEARCH && game_run && w_found) ? (ONE_HOT0 << w_idx) : '0;
  assign w_drop_k     = (r_state == REQ && game_run && w_timeout) ? r_start : '0;
  assign w_active_nxt = (r_active & ~w_release & ~w_drop_k) | w_set;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register sees the pre-edge values of the others regardless of order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_drop_q   <= 1'b0;
      r_busy_q   <= '0;
      r_ptr      <= '0;
      r_to       <= '0;
      r_start    <= '0;
      r_active   <= '0;
      r_spawn    <= '0;
      r_miss     <= '0;
      r_all_busy <= 1'b0;
`ifdef BARREL_COOLDOWN_EN
      r_cool     <= '0;
`endif
    end else if (game_clear) begin
      r_state    <= IDLE;
      r_drop_q   <= 1'b0;
      r_busy_q   <= '0;
      r_ptr      <= '0;
      r_to       <= '0;
      r_start    <= '0;
      r_active   <= '0;
      r_spawn    <= '0;
      r_miss     <= '0;
      r_all_busy <= 1'b0;
`ifdef BARREL_COOLDOWN_EN
      r_cool     <= '0;
`endif
    end else if (tick) begin
      r_drop_q   <= drop_req;
      r_busy_q   <= slot_busy;
      r_active   <= w_active_nxt;
      r_all_busy <= &w_active_nxt;
`ifdef BARREL_COOLDOWN_EN
      // Free-running down-count; also drains if game_run drops mid-cooldown.
      if (r_cool != 8'd0) r_cool <= r_cool - 8'd1;
`endif
      case (r_state)
        IDLE: begin
          if (w_drop_evt && game_run) begin
            if (w_cool_ok) r_state <= SEARCH;
            else           r_miss  <= sat_inc(r_miss);
          end
        end
        SEARCH: begin
          if (!game_run) begin
            r_state <= IDLE;
          end else if (w_found) begin
            r_start <= ONE_HOT0 << w_idx;
            r_ptr   <= w_ptr_nxt;
            r_to    <= '0;
            r_state <= REQ;
          end else begin
            r_miss  <= sat_inc(r_miss);
            r_state <= IDLE;
          end
        end
        REQ: begin
          if (!game_run) begin
            r_start <= '0;
            r_state <= IDLE;
          end else if (w_ack || w_timeout) begin
            r_start <= '0;
            if (w_ack) r_spawn <= sat_inc(r_spawn);
            else       r_miss  <= sat_inc(r_miss);
`ifdef BARREL_COOLDOWN_EN
            r_cool  <= COOL_LOAD;
            r_state <= COOL;
`else
            r_state <= IDLE;
`endif
          end else begin
            r_to <= r_to + 3'd1;
          end
        end
        COOL: begin
`ifdef BARREL_COOLDOWN_EN
          if (!game_run) begin
            r_state <= IDLE;
          end else begin
            if (w_drop_evt) r_miss <= sat_inc(r_miss);
            if (r_cool <= 8'd1) r_state <= IDLE;
          end
`else
          r_state <= IDLE;
`endif
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign slot_start  = r_start;
  assign active_mask = r_active;
  assign spawn_count = r_spawn;
  assign miss_count  = r_miss;
  assign all_busy    = r_all_busy;

endmodule

// File: doc/barrel_dispatcher.md
BARREL_DISPATCHER -- requirements
Module: barrel_dispatcher

Interface
REQ-001 Parameter NUM_SLOTS, default 16: number of barrel slots managed, 2..16.
REQ-002 Parameter COOLDOWN_TICKS, default 32: minimum ticks between successive spawns, 1..255.
REQ-003 clk  in  1  system clock; single clock domain.
REQ-004 rst_n  in  1  asynchronous active-low reset.
REQ-005 tick  in  1  one-clk game-rate enable; all state advances only on clk edges with tick=1.
REQ-006 game_run  in  1  high while game state is RUNNING.
REQ-007 game_clear  in  1  synchronous clear, high while game state is INITIAL.
REQ-008 drop_req  in  1  level, high while the kong animation is in DROP pose.
REQ-009 slot_busy  in  NUM_SLOTS  per-slot flag, high while that barrel is rolling or falling.
REQ-010 slot_start  out  NUM_SLOTS  one-hot-or-zero start request to barrel slots.
REQ-011 active_mask  out  NUM_SLOTS  slots allocated by this block and not yet released.
REQ-012 spawn_count  out  8  total spawns since reset/clear, saturating at 255.
REQ-013 miss_count  out  8  drop events discarded (no free slot or cooldown), saturating at 255.
REQ-014 all_busy  out  1  high when active_mask is all ones.

Function
REQ-015 Drop event = rising edge of drop_req sampled on tick; one event per edge regardless of level duration.
REQ-016 FSM states: IDLE, SEARCH, REQ, COOL.
REQ-017 IDLE: on drop event with game_run=1 and cooldown expired -> SEARCH; otherwise event counts to miss_count if game_run=1, ignored if game_run=0.
REQ-018 SEARCH: one tick; selects lowest-index free slot at or after round-robin pointer, wrapping past NUM_SLOTS-1 to 0; free = active_mask[i]=0 and slot_busy[i]=0.
REQ-019 SEARCH with no free slot: miss_count increments, -> IDLE, pointer unchanged.
REQ-020 SEARCH with slot k found: slot_start[k]=1, active_mask[k]=1, pointer <= k+1 mod NUM_SLOTS, -> REQ.
REQ-021 REQ: slot_start[k] held high until slot_busy[k]=1 observed on a tick, then deasserted next tick; spawn_count increments at acknowledge; -> COOL.
REQ-022 REQ timeout: no acknowledge within 8 ticks -> slot_start cleared, active_mask[k] cleared, miss_count increments, -> COOL.
REQ-023 COOL: cooldown counter loaded with COOLDOWN_TICKS on entry, decrements per tick, -> IDLE at zero; drop events in COOL count as misses.
REQ-024 Release: active_mask[i] cleared on tick when slot_busy[i] falls 1->0; applies to any slot, concurrently with any state.
REQ-025 Simultaneous release of slot j and SEARCH: released slot is not eligible until the following tick.
REQ-026 game_run falling in SEARCH/REQ/COOL: slot_start cleared, -> IDLE; active_mask retained.
REQ-027 game_clear: same effect as reset on all state and outputs, takes priority over tick.
REQ-028 At most one slot_start bit high at any time.
REQ-029 Counters saturate at 255, never wrap.

Reset
REQ-030 rst_n low asynchronously forces: FSM IDLE, slot_start=0, active_mask=0, pointer=0, cooldown=0, spawn_count=0, miss_count=0, drop_req edge register=0, all_busy=0.
REQ-031 Outputs are registered; reset release takes effect on first clk edge with rst_n high.

Configuration
REQ-032 Macro BARREL_COOLDOWN_EN: when defined, COOL state and cooldown counter exist as per REQ-023.
REQ-033 Without BARREL_COOLDOWN_EN: REQ exits directly to IDLE, no cooldown misses, COOLDOWN_TICKS ignored.

Verification
REQ-034 Reset, game_run=1, one drop_req pulse, slot_busy[0] acked 2 ticks later -> slot_start=0x0001 for 2 ticks, active_mask=0x0001, spawn_count=1.
REQ-035 16 spawns acked and held busy, 17th drop -> no slot_start, miss_count=1, all_busy=1.
REQ-036 Slots 0..15 active, slot 5 drops busy, pointer at 0, next drop -> slot_start=0x0020.
REQ-037 Spawn to slot 3, never ack -> start cleared after 8 ticks, active_mask[3]=0, miss_count=1, spawn_count unchanged.
REQ-038 BARREL_COOLDOWN_EN, COOLDOWN_TICKS=32, second drop 10 ticks after ack -> miss_count=1; third drop 40 ticks after -> spawns.
REQ-039 rst_n low mid-REQ -> slot_start=0, all counters 0 immediately without clk edge.
